// File: rtl/main_memory_responder_if.sv
// Bus between the cache's main-memory read port and the memory responder:
// read request/beat stream plus a single-cycle write port.
interface main_memory_responder_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  read_req;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic                  data_valid;
  logic                  last;
  logic                  write_en;
  logic [ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0] write_data;

  modport master (
    output read_req, addr, write_en, write_addr, write_data,
    input  ready, data, data_valid, last
  );

  modport slave (
    input  read_req, addr, write_en, write_addr, write_data,
    output ready, data, data_valid, last
  );
endinterface

// File: rtl/main_memory_responder.sv
// Word-addressed backing memory that answers line-fill requests after a fixed
// latency with a critical-word-first, block-wrapping burst.
module main_memory_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WORDS  = 1024,
  parameter int LATENCY    = 4,
  parameter int BURST_LEN  = 1
) (
  input logic                    clk,
  input logic                    rst,
  main_memory_responder_if.slave bus
);
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [IDX_W-1:0]  BURST_MASK = IDX_W'(BURST_LEN - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [LAT_W-1:0]  LAT_LOAD   = LAT_W'(LATENCY - 1);

  generate
    if (LATENCY < 1 || MEM_WORDS < 2 || (MEM_WORDS & (MEM_WORDS - 1)) != 0 ||
        BURST_LEN < 1 || BURST_LEN > 16 || BURST_LEN > MEM_WORDS ||
        (BURST_LEN & (BURST_LEN - 1)) != 0) begin : g_bad_params
      $error("main_memory_responder: illegal LATENCY/BURST_LEN/MEM_WORDS");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

  state_t                state;
  logic                  ready_q;
  logic                  valid_q;
  logic                  last_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [IDX_W-1:0]      idx;
  logic [LAT_W-1:0]      lat_cnt;
  logic [BEAT_W-1:0]     beat_cnt;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] beat_idx;

  // Byte offset and bits above the array depth are dropped, so addresses alias.
  assign req_idx  = bus.addr[IDX_W+1:2];
  assign wr_idx   = bus.write_addr[IDX_W+1:2];
  assign beat_idx = (idx & ~BURST_MASK) | ((idx + IDX_W'(beat_cnt)) & BURST_MASK);

  assign bus.ready      = ready_q;
  assign bus.data_valid = valid_q;
  assign bus.last       = last_q;
  assign bus.data       = data_q;

  // Contents survive reset; a beat read in the write's own cycle sees the old word.
  always_ff @(posedge clk) begin
    if (bus.write_en) mem[wr_idx] <= bus.write_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      data_q   <= '0;
      idx      <= '0;
      lat_cnt  <= '0;
      beat_cnt <= '0;
    end else begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
      case (state)
        S_IDLE: begin
          // ready_q is low for the first idle cycle after a burst, giving the gap.
          ready_q <= 1'b1;
          if (ready_q && bus.read_req) begin
            ready_q  <= 1'b0;
            idx      <= req_idx;
            lat_cnt  <= LAT_LOAD;
            beat_cnt <= '0;
            if (LATENCY == 1) state <= S_BURST;
            else              state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt <= LAT_W'(1)) state <= S_BURST;
          else                      lat_cnt <= lat_cnt - 1'b1;
        end
        S_BURST: begin
          valid_q  <= 1'b1;
          data_q   <= mem[beat_idx];
          last_q   <= (beat_cnt == LAST_BEAT);
          beat_cnt <= beat_cnt + 1'b1;
          if (beat_cnt == LAST_BEAT) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_main_memory_responder.sv
// Directed bench for main_memory_responder: one single-beat instance (LATENCY 4)
// and one wrapping-burst instance (LATENCY 2, BURST_LEN 4, 64 words).
module tb_main_memory_responder;
  localparam int LAT_A = 4;
  localparam int LAT_B = 2;
  localparam int BL_B  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  main_memory_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
  main_memory_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifb ();

  main_memory_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(1024), .LATENCY(LAT_A), .BURST_LEN(1)
  ) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));

  main_memory_responder #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_WORDS(64), .LATENCY(LAT_B), .BURST_LEN(BL_B)
  ) dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));

  typedef struct {
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] ra;
    logic [31:0] rd;
  } vec_t;

  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeA(input logic [31:0] a, input logic [31:0] d);
    ifa.write_en = 1'b1; ifa.write_addr = a; ifa.write_data = d;
    tick();
    ifa.write_en = 1'b0;
  endtask

  task automatic writeB(input logic [31:0] a, input logic [31:0] d);
    ifb.write_en = 1'b1; ifb.write_addr = a; ifb.write_data = d;
    tick();
    ifb.write_en = 1'b0;
  endtask

  task automatic waitValidA(output int cyc);
    cyc = 0;
    do begin tick(); cyc++; end while (!ifa.data_valid && cyc < 20);
  endtask

  task automatic waitValidB(output int cyc);
    cyc = 0;
    do begin tick(); cyc++; end while (!ifb.data_valid && cyc < 20);
  endtask

  task automatic applyStimulus(input logic [31:0] a);
    checkOutput("a_ready_before_req", 32'(ifa.ready), 32'd1);
    ifa.read_req = 1'b1; ifa.addr = a;
    tick();
    ifa.read_req = 1'b0;
    checkOutput("a_ready_after_accept", 32'(ifa.ready), 32'd0);
  endtask

  task automatic requestA(input logic [31:0] a, input logic [31:0] exp_d);
    int cyc;
    applyStimulus(a);
    waitValidA(cyc);
    checkOutput("a_latency", 32'(cyc), 32'(LAT_A));
    checkOutput("a_data", ifa.data, exp_d);
    checkOutput("a_last", 32'(ifa.last), 32'd1);
    checkOutput("a_ready_during_beat", 32'(ifa.ready), 32'd0);
    tick();
    checkOutput("a_valid_after_beat", 32'(ifa.data_valid), 32'd0);
    checkOutput("a_data_zero_idle", ifa.data, 32'd0);
    checkOutput("a_ready_after_burst", 32'(ifa.ready), 32'd1);
  endtask

  task automatic requestB(input logic [31:0] a, input logic [31:0] exp_d [BL_B],
                          input int col_beat, input logic [31:0] col_addr,
                          input logic [31:0] col_data);
    int cyc;
    checkOutput("b_ready_before_req", 32'(ifb.ready), 32'd1);
    ifb.read_req = 1'b1; ifb.addr = a;
    tick();
    ifb.read_req = 1'b0;
    checkOutput("b_ready_after_accept", 32'(ifb.ready), 32'd0);
    waitValidB(cyc);
    checkOutput("b_latency", 32'(cyc), 32'(LAT_B));
    for (int k = 0; k < BL_B; k++) begin
      if (k > 0) begin
        // A write staged here lands on the same edge that reads beat k.
        if (k == col_beat) begin
          ifb.write_en = 1'b1; ifb.write_addr = col_addr; ifb.write_data = col_data;
        end
        tick();
        ifb.write_en = 1'b0;
      end
      checkOutput($sformatf("b_valid_beat%0d", k), 32'(ifb.data_valid), 32'd1);
      checkOutput($sformatf("b_data_beat%0d", k), ifb.data, exp_d[k]);
      checkOutput($sformatf("b_last_beat%0d", k), 32'(ifb.last), (k == BL_B - 1) ? 32'd1 : 32'd0);
    end
    tick();
    checkOutput("b_valid_after_burst", 32'(ifb.data_valid), 32'd0);
    checkOutput("b_last_after_burst", 32'(ifb.last), 32'd0);
    checkOutput("b_ready_after_burst", 32'(ifb.ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs [4];
    logic [31:0] e [BL_B];
    int          cyc;
    logic        saw_valid;

    vecs[0] = '{wa: 32'h0000_0014, wd: 32'hDEAD_BEEF, ra: 32'h0000_0014, rd: 32'hDEAD_BEEF};
    vecs[1] = '{wa: 32'h0000_1000, wd: 32'h0000_0077, ra: 32'h0000_0000, rd: 32'h0000_0077};
    vecs[2] = '{wa: 32'h0000_0023, wd: 32'h1234_5678, ra: 32'h0000_0020, rd: 32'h1234_5678};
    vecs[3] = '{wa: 32'h0000_0FFC, wd: 32'hCAFE_0001, ra: 32'h0000_7FFC, rd: 32'hCAFE_0001};

    ifa.read_req = 1'b0; ifa.addr = '0; ifa.write_en = 1'b0; ifa.write_addr = '0; ifa.write_data = '0;
    ifb.read_req = 1'b0; ifb.addr = '0; ifb.write_en = 1'b0; ifb.write_addr = '0; ifb.write_data = '0;

    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    tick();
    checkOutput("a_reset_ready", 32'(ifa.ready), 32'd1);
    checkOutput("a_reset_valid", 32'(ifa.data_valid), 32'd0);
    checkOutput("a_reset_last", 32'(ifa.last), 32'd0);
    checkOutput("a_reset_data", ifa.data, 32'd0);
    checkOutput("b_reset_ready", 32'(ifb.ready), 32'd1);
    checkOutput("b_reset_valid", 32'(ifb.data_valid), 32'd0);

    // Single-beat table: preload, then fetch (includes byte-offset and alias wraps).
    for (int i = 0; i < 4; i++) begin
      writeA(vecs[i].wa, vecs[i].wd);
      requestA(vecs[i].ra, vecs[i].rd);
    end

    // Held request: re-accepted one idle cycle after the beat; address change mid-flight ignored.
    ifa.read_req = 1'b1; ifa.addr = 32'h14;
    tick();
    ifa.addr = 32'h20;
    waitValidA(cyc);
    checkOutput("held_latency1", 32'(cyc), 32'(LAT_A));
    checkOutput("held_data1", ifa.data, 32'hDEAD_BEEF);
    checkOutput("held_last1", 32'(ifa.last), 32'd1);
    tick();
    checkOutput("held_gap_valid", 32'(ifa.data_valid), 32'd0);
    checkOutput("held_gap_ready", 32'(ifa.ready), 32'd1);
    tick();
    checkOutput("held_reaccept_ready", 32'(ifa.ready), 32'd0);
    ifa.read_req = 1'b0;
    waitValidA(cyc);
    checkOutput("held_latency2", 32'(cyc), 32'(LAT_A));
    checkOutput("held_data2", ifa.data, 32'h1234_5678);
    tick();
    checkOutput("held_ready_end", 32'(ifa.ready), 32'd1);

    // Reset two cycles into WAIT aborts the request without touching memory.
    ifa.read_req = 1'b1; ifa.addr = 32'h14;
    tick();
    ifa.read_req = 1'b0;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_ready_async", 32'(ifa.ready), 32'd1);
    checkOutput("abort_valid_async", 32'(ifa.data_valid), 32'd0);
    tick();
    #2 rst = 1'b0;
    saw_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ifa.data_valid) saw_valid = 1'b1;
    end
    checkOutput("abort_no_beat", 32'(saw_valid), 32'd0);
    checkOutput("abort_ready_after", 32'(ifa.ready), 32'd1);
    requestA(32'h14, 32'hDEAD_BEEF);

    // Wrapping burst on the 4-beat instance.
    for (int k = 0; k < 4; k++) writeB(32'h20 + 32'(4 * k), 32'hA000_0000 + 32'(k));
    e = '{32'hA000_0002, 32'hA000_0003, 32'hA000_0000, 32'hA000_0001};
    requestB(32'h28, e, -1, 32'h0, 32'h0);
    requestB(32'h28, e, 1, 32'h2C, 32'h55);
    e = '{32'h0000_0055, 32'hA000_0000, 32'hA000_0001, 32'hA000_0002};
    requestB(32'h2C, e, -1, 32'h0, 32'h0);
    e = '{32'hA000_0002, 32'h0000_0055, 32'hA000_0000, 32'hA000_0001};
    requestB(32'h128, e, -1, 32'h0, 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
